// File: rtl/img_pre_process.sv
// Streaming RGB888 -> luma -> 3x3 Gaussian smoothing; fixed 4-cycle latency, no back-pressure.
// Build option: define SMOOTH_BYPASS_EN to drop the line buffers/filter and emit raw luma (latency 2).
module img_pre_process #(
  parameter int unsigned MAX_WIDTH = 1024,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] r_data,
  input  logic [DATA_W-1:0] g_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [11:0]       img_width,
  output logic              dout_valid,
  output logic [DATA_W-1:0] proc_data
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = DATA_W + 4;

  // Luma: weights sum to 256 so the top byte of the product sum is the gray value
  logic [PROD_W-1:0] gray_sum_c;
  logic [DATA_W-1:0] gray_c;

  assign gray_sum_c = PROD_W'(r_data) * PROD_W'(77)
                    + PROD_W'(g_data) * PROD_W'(150)
                    + PROD_W'(b_data) * PROD_W'(29);
  assign gray_c     = gray_sum_c[PROD_W-1 -: DATA_W];

  logic              valid_s1;
  logic [DATA_W-1:0] gray_s1;
  logic              valid_s2;
  logic [DATA_W-1:0] gray_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s1 <= 1'b0;
      valid_s2 <= 1'b0;
    end else begin
      valid_s1 <= din_valid;
      valid_s2 <= valid_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (din_valid) gray_s1 <= gray_c;
    if (valid_s1)  gray_s2 <= gray_s1;
  end

`ifdef SMOOTH_BYPASS_EN

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      proc_data  <= '0;
    end else begin
      dout_valid <= valid_s2;
      if (valid_s2) proc_data <= gray_s2;
    end
  end

`else

  localparam int unsigned COL_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned IW    = 12;

  logic [COL_W-1:0]  col_q;
  logic [1:0]        row_q;
  logic [IW-1:0]     width_eff_c;
  logic              last_col_c;
  logic              emit_c;

  assign width_eff_c = (img_width > IW'(MAX_WIDTH)) ? IW'(MAX_WIDTH) : img_width;
  assign last_col_c  = (IW'(col_q) == (width_eff_c - IW'(1)));
  assign emit_c      = din_valid && (width_eff_c >= IW'(3)) &&
                       (row_q == 2'd2) && (col_q >= COL_W'(2));

  // Raster position; row saturates at 2 since only "has two lines above" matters
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (din_valid) begin
      if (last_col_c) begin
        col_q <= '0;
        if (row_q != 2'd2) row_q <= row_q + 2'd1;
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  logic [COL_W-1:0]  col_s1;
  logic              emit_s1;
  logic              emit_s2;
  logic              emit_s3;
  logic              emit_s4;
  logic [DATA_W-1:0] top_s2;
  logic [DATA_W-1:0] mid_s2;
  logic [DATA_W-1:0] lb0 [MAX_WIDTH];
  logic [DATA_W-1:0] lb1 [MAX_WIDTH];
  logic [2:0][DATA_W-1:0] win_t;
  logic [2:0][DATA_W-1:0] win_m;
  logic [2:0][DATA_W-1:0] win_b;
  logic [SUM_W-1:0]  sum_c;
  logic [SUM_W-1:0]  sum_s4;

  always_ff @(posedge clk) begin
    if (rst) begin
      emit_s1    <= 1'b0;
      emit_s2    <= 1'b0;
      emit_s3    <= 1'b0;
      emit_s4    <= 1'b0;
      dout_valid <= 1'b0;
      proc_data  <= '0;
    end else begin
      emit_s1    <= emit_c;
      emit_s2    <= emit_s1;
      emit_s3    <= emit_s2;
      emit_s4    <= emit_s3;
      dout_valid <= emit_s4;
      if (emit_s4) proc_data <= sum_s4[SUM_W-1 -: DATA_W];
    end
  end

  // Cascaded line buffers: lb0 holds row r-1, lb1 takes the evicted lb0 word (row r-2)
  always_ff @(posedge clk) begin
    if (din_valid) col_s1 <= col_q;
    if (valid_s1) begin
      lb0[col_s1] <= gray_s1;
      lb1[col_s1] <= lb0[col_s1];
      top_s2      <= lb1[col_s1];
      mid_s2      <= lb0[col_s1];
    end
  end

  // Window shifts only on real pixels so input gaps are transparent
  always_ff @(posedge clk) begin
    if (valid_s2) begin
      win_t <= {win_t[1:0], top_s2};
      win_m <= {win_m[1:0], mid_s2};
      win_b <= {win_b[1:0], gray_s2};
    end
    sum_s4 <= sum_c;
  end

  assign sum_c = SUM_W'(win_t[0]) + (SUM_W'(win_t[1]) << 1) + SUM_W'(win_t[2])
               + (SUM_W'(win_m[0]) << 1) + (SUM_W'(win_m[1]) << 2) + (SUM_W'(win_m[2]) << 1)
               + SUM_W'(win_b[0]) + (SUM_W'(win_b[1]) << 1) + SUM_W'(win_b[2]);

`endif

endmodule

// File: tb/tb_img_pre_process.sv
// Directed bench for img_pre_process with a latency-aware output scoreboard.
module tb_img_pre_process;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic [7:0]  r_data, g_data, b_data;
  logic [11:0] img_width;
  logic        dout_valid;
  logic [7:0]  proc_data;

`ifdef SMOOTH_BYPASS_EN
  localparam int LAT = 3;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 5;
  localparam bit BYP = 1'b0;
`endif

  // Impulse response of a 255 centre pixel: 255*{1,2,4}/16 truncated
  localparam int IMP [3][3] = '{'{15, 31, 15}, '{31, 63, 31}, '{15, 31, 15}};

  img_pre_process dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .r_data     (r_data),
    .g_data     (g_data),
    .b_data     (b_data),
    .img_width  (img_width),
    .dout_valid (dout_valid),
    .proc_data  (proc_data)
  );

  always #5 clk = ~clk;

  int pc = 0;
  always @(posedge clk) pc <= pc + 1;

  typedef struct {int val; int cyc;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int out_cnt = 0;

  // Output samples are checked against the queue, including their arrival cycle
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      out_cnt++;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got proc_data=%0d at cyc %0d, required no output", proc_data, pc);
      end else begin
        mon_e = sbq.pop_front();
        if (proc_data !== 8'(mon_e.val) || pc != mon_e.cyc) begin
          bad++;
          $display("FAIL out_sample: got %0d at cyc %0d, required %0d at cyc %0d",
                   proc_data, pc, mon_e.val, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      r_data = 8'($urandom);
      g_data = 8'($urandom);
      b_data = 8'($urandom);
    end
  endtask

  task automatic send_px(input int r, input int g, input int b, input int gray,
                         input bit emit, input int filt, input bit push);
    @(negedge clk);
    din_valid = 1'b1;
    r_data = 8'(r);
    g_data = 8'(g);
    b_data = 8'(b);
    if (push) begin
      if (BYP) sbq.push_back('{gray, pc + LAT});
      else if (emit) sbq.push_back('{filt, pc + LAT});
    end
  endtask

  task automatic do_reset(input int w);
    idle(8);
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    img_width = 12'(w);
  endtask

  task automatic const_frame(input int w, input int rows, input int r, input int g, input int b,
                             input int gray, input int filt, input int gap);
    for (int row = 0; row < rows; row++) begin
      for (int col = 0; col < w; col++)
        send_px(r, g, b, gray, (row >= 2) && (col >= 2) && (w >= 3), filt, 1'b1);
      idle(gap);
    end
  endtask

  task automatic impulse(input bit gaps);
    int v;
    for (int row = 0; row < 5; row++) begin
      for (int col = 0; col < 5; col++) begin
        v = (row == 2 && col == 2) ? 255 : 0;
        send_px(v, v, v, v, (row >= 2) && (col >= 2),
                (row >= 2 && col >= 2) ? IMP[row-2][col-2] : 0, 1'b1);
        if (gaps) idle(int'($urandom_range(0, 1)));
      end
    end
  endtask

  int base;

  initial begin
    rst = 1'b1;
    din_valid = 1'b1;
    r_data = 8'd255; g_data = 8'd255; b_data = 8'd255;
    img_width = 12'd8;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_dout_valid", int'(dout_valid), 0);
      chk("rst_proc_data", int'(proc_data), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;

    // Channel weights on constant frames
    const_frame(8, 3, 255, 0, 0, 76, 76, 2);
    do_reset(8);
    const_frame(8, 3, 0, 255, 0, 149, 149, 2);
    do_reset(8);
    const_frame(8, 3, 0, 0, 255, 28, 28, 2);
    do_reset(8);
    const_frame(8, 3, 100, 100, 100, 100, 100, 2);

    // Horizontal ramp 16,32,48,64 on every row: outputs 32 then 48
    do_reset(4);
    for (int row = 0; row < 3; row++) begin
      for (int col = 0; col < 4; col++)
        send_px(16*(col+1), 16*(col+1), 16*(col+1), 16*(col+1),
                (row >= 2) && (col >= 2), (col == 2) ? 32 : 48, 1'b1);
      idle(3);
    end

    // Single bright row passes through bottom, middle, top of the window: 40, 80, 40
    do_reset(3);
    for (int row = 0; row < 5; row++) begin
      for (int col = 0; col < 3; col++)
        send_px((row == 2) ? 160 : 0, (row == 2) ? 160 : 0, (row == 2) ? 160 : 0,
                (row == 2) ? 160 : 0, (row >= 2) && (col == 2),
                (row == 3) ? 80 : 40, 1'b1);
      idle(1);
    end

    do_reset(5);
    impulse(1'b0);
    do_reset(5);
    impulse(1'b1);

    // Too-narrow lines: filtered build emits nothing, bypass emits every pixel
    do_reset(2);
    base = out_cnt;
    const_frame(2, 4, 37, 37, 37, 37, 0, 1);
    idle(8);
    chk("width2_count", out_cnt - base, BYP ? 8 : 0);

    // Long lines with inter-line gaps
    do_reset(640);
    base = out_cnt;
    const_frame(640, 5, 50, 50, 50, 50, 50, 10);
    idle(8);
    chk("w640_count", out_cnt - base, BYP ? 3200 : 1914);

    // Reset in the middle of row 2 drops the in-flight pixels
    do_reset(5);
    const_frame(5, 2, 100, 100, 100, 100, 100, 0);
    send_px(100, 100, 100, 100, 1'b0, 0, 1'b1);
    send_px(100, 100, 100, 100, 1'b0, 0, 1'b1);
    send_px(100, 100, 100, 100, 1'b0, 0, 1'b0);
    send_px(100, 100, 100, 100, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    chk("midrst_dout_valid", int'(dout_valid), 0);
    chk("midrst_proc_data", int'(proc_data), 0);
    rst = 1'b0;
    base = out_cnt;
    const_frame(5, 3, 100, 100, 100, 100, 100, 0);
    idle(10);
    chk("midrst_count", out_cnt - base, BYP ? 15 : 3);

    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/img_pre_process.md
Name: img_pre_process

Overview:
- Streaming image pre-processor: RGB888 pixels in, 8-bit smoothed grayscale out.
- Stage 1 converts each pixel to luma.
- Stage 2 applies a 3x3 Gaussian smoothing filter using two internal line buffers, with line width set at run time.
- Sits between the camera/pixel source and downstream feature extraction; there is no back-pressure.

Parameters:
- MAX_WIDTH, 1024, line-buffer depth; largest supported line width.
- DATA_W, 8, bits per colour channel and per output sample.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- din_valid  in  1  r/g/b_data hold a pixel this cycle; pixels arrive in raster order.
- r_data  in  8  red channel.
- g_data  in  8  green channel.
- b_data  in  8  blue channel.
- img_width  in  12  active pixels per line; legal range 3..MAX_WIDTH.
- dout_valid  out  1  proc_data valid this cycle (single-cycle strobe per output sample).
- proc_data  out  8  filtered grayscale sample.

Behaviour:
- Reset: while rst=1 at a clock edge, the following all clear to 0: dout_valid, proc_data, column counter, row counter/flags, and every pipeline valid bit. Line-buffer RAM contents are not cleared (don't care).
- Reset mid-line discards all in-flight pixels; the next valid pixel is treated as row 0, column 0.
- Gray conversion: gray = (77*R + 150*G + 29*B) >> 8, truncated, held in a 16-bit intermediate; result always fits in 8 bits (255,255,255 -> 255).
- Pixel counting: the column counter advances only on din_valid=1 and wraps from img_width-1 to 0.
- The row counter increments on each wrap and saturates at 2; no end-of-frame handling; gaps of any length (din_valid=0) are transparent.
- img_width is sampled every cycle and may change only while no pixel is in flight and the column counter is 0.
- img_width above MAX_WIDTH is treated as MAX_WIDTH.
- img_width below 3 means no output is ever produced; the counters still run.
- Line buffers: two cascaded 8-bit RAMs of depth MAX_WIDTH, addressed by column, holding gray rows r-1 and r-2. Each is written with the gray sample as it arrives.
- Window: 3x3 shift window built from the current gray sample and the two line-buffer outputs at the same column.
- Filter kernel: [1 2 1; 2 4 2; 1 2 1]. Sum held in 12 bits; result = sum >> 4, truncated (no rounding).
- Output rule: for the input pixel accepted at edge N with row >= 2 and column >= 2, dout_valid=1 for exactly one cycle after edge N+4 (fixed latency 4). proc_data is the filtered value of the window whose bottom-right pixel is that input, i.e. centre (row-1, column-1).
- Pixels with row < 2 or column < 2 produce no output (borders dropped). A full line with row >= 2 yields img_width-2 outputs.
- The pipeline advances every cycle. Gaps in din_valid create matching gaps in dout_valid, with the same latency and no loss or duplication.
- proc_data holds its last value while dout_valid=0.

Optional Feature:
- Macro SMOOTH_BYPASS_EN.
- Defined: line buffers and filter are not built. Every valid input produces an output (no border drop). proc_data = gray. Latency is 2 cycles (dout_valid after edge N+2).
- Undefined: full behaviour as above.

Test Plan:
- Reset checks: hold rst=1 for 3 cycles with din_valid=1 -> dout_valid=0 and proc_data=0 throughout. Assert rst for 1 cycle mid-line 3 -> no outputs until a new row 2, column 2 pixel has arrived.
- Channel weights: img_width=8, 3 lines of constant R=255,G=0,B=0 -> every output = 76. Repeat with G-only -> 149; B-only -> 28; R=G=B=100 -> 100.
- Output count: img_width=640, 5 lines of random RGB, 10-cycle gaps between lines -> exactly 3*638 = 1914 dout_valid pulses. Each value matches a reference model of gray conversion plus kernel; each pulse comes 4 cycles after its input.
- Impulse: img_width=5, all pixels 0 except pixel (row 2, column 2) = R=G=B=255 -> output centred on (2,2) = 63. Edge neighbours = 31, corner neighbours = 15, all others = 0.
- Gaps: insert random single-cycle din_valid drops inside lines -> output stream values identical to the gap-free run. Each output still comes 4 cycles after its input.
- Width handling: img_width=2 for 4 lines -> no dout_valid. With SMOOTH_BYPASS_EN defined, R=G=B=37 -> proc_data=37 with latency 2 on every valid input.
